// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data; data wins unless fetch has waited STARVE_MAX grants.
// Grant 1 clk after request, rvalid 1 clk after mem_ack; one transaction outstanding, requesters hold until gnt.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_flush,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    starve_cnt_q;
    logic                drop_fetch_q;
    logic                if_gnt_q;
    logic                if_rvalid_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic                d_gnt_q;
    logic                d_rvalid_q;
    logic [DATA_W-1:0]   d_rdata_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [STRB_W-1:0]   mem_wstrb_q;
    logic                busy_q;

    logic starved;
    logic pick_d;
    logic pick_i;

    // Once fetch has watched STARVE_MAX data grants go by, data must yield one slot.
    assign starved = if_req && (starve_cnt_q == CNT_MAX);
    assign pick_d  = d_req && !starved;
    assign pick_i  = !pick_d && if_req && !if_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            drop_fetch_q <= 1'b0;
            if_gnt_q     <= 1'b0;
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            d_gnt_q      <= 1'b0;
            d_rvalid_q   <= 1'b0;
            d_rdata_q    <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if (!if_req) begin
                starve_cnt_q <= '0;
            end

            case (state_q)
                IDLE: begin
                    if (pick_d) begin
                        state_q     <= BUSY_D;
                        busy_q      <= 1'b1;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= d_we;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                        mem_wstrb_q <= d_wstrb;
                        d_gnt_q     <= 1'b1;
                        if (if_req && (starve_cnt_q != CNT_MAX)) begin
                            starve_cnt_q <= starve_cnt_q + CNT_W'(1);
                        end
                    end else if (pick_i) begin
                        state_q      <= BUSY_I;
                        busy_q       <= 1'b1;
                        mem_req_q    <= 1'b1;
                        mem_we_q     <= 1'b0;
                        mem_addr_q   <= if_addr;
                        mem_wdata_q  <= '0;
                        mem_wstrb_q  <= '0;
                        if_gnt_q     <= 1'b1;
                        starve_cnt_q <= '0;
                    end
                end
                BUSY_I: begin
                    if (if_flush) begin
                        drop_fetch_q <= 1'b1;
                    end
                    if (mem_ack) begin
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                        mem_req_q    <= 1'b0;
                        drop_fetch_q <= 1'b0;
                        // A flush arriving on the ack cycle still kills the response.
                        if (!(drop_fetch_q || if_flush)) begin
                            if_rvalid_q <= 1'b1;
                            if_rdata_q  <= mem_rdata;
                        end
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        mem_req_q  <= 1'b0;
                        d_rvalid_q <= 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_q <= mem_rdata;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign if_gnt    = if_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_gnt     = d_gnt_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: scripted requesters, a memory responder with programmable ack delay,
// and a negedge monitor popping expected memory transactions and read data from queues.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_exp_t;

    mem_exp_t    exp_mem_q[$];
    logic [31:0] exp_if_q[$];
    logic [31:0] exp_d_q[$];
    logic [31:0] last_load = 32'h0;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        return (a ^ 32'hC0DE_0000) + 32'h7;
    endfunction

    task automatic push_fetch(input logic [31:0] a, input bit deliver);
        exp_mem_q.push_back('{1'b0, a, 32'h0, 4'h0});
        if (deliver) exp_if_q.push_back(mem_val(a));
    endtask

    task automatic push_load(input logic [31:0] a, input bit deliver);
        exp_mem_q.push_back('{1'b0, a, 32'h0, 4'h0});
        if (deliver) begin
            last_load = mem_val(a);
            exp_d_q.push_back(last_load);
        end
    endtask

    task automatic push_store(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
        exp_mem_q.push_back('{1'b1, a, w, s});
        exp_d_q.push_back(last_load);
    endtask

    // Memory responder: acks ack_delay cycles after it first sees mem_req.
    logic resp_en   = 1'b1;
    logic man_ack   = 1'b0;
    int   ack_delay = 1;
    int   resp_cnt  = 0;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
    end

    always @(posedge clk) begin
        #1;
        if (!resp_en) begin
            resp_cnt  = 0;
            mem_ack   = man_ack;
            mem_rdata = 32'hBAD0_BAD0;
        end else if (mem_ack) begin
            mem_ack  = 1'b0;
            resp_cnt = 0;
        end else if (mem_req) begin
            if (resp_cnt == ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_val(mem_addr);
            end else begin
                resp_cnt++;
            end
        end else begin
            resp_cnt = 0;
        end
    end

    logic        mem_req_prev = 1'b0;
    mem_exp_t    mon_e;
    logic [31:0] mon_d;

    always @(negedge clk) begin
        if (mem_req && !mem_req_prev) begin
            tests++;
            if (exp_mem_q.size() == 0) begin
                fails++;
                $display("FAIL mem_txn: unexpected request addr=%h we=%0b", mem_addr, mem_we);
            end else begin
                mon_e = exp_mem_q.pop_front();
                if (mem_addr !== mon_e.addr || mem_we !== mon_e.we ||
                    (mon_e.we && (mem_wdata !== mon_e.wdata || mem_wstrb !== mon_e.wstrb))) begin
                    fails++;
                    $display("FAIL mem_txn: got addr=%h we=%0b wdata=%h wstrb=%b, want addr=%h we=%0b wdata=%h wstrb=%b",
                             mem_addr, mem_we, mem_wdata, mem_wstrb,
                             mon_e.addr, mon_e.we, mon_e.wdata, mon_e.wstrb);
                end
            end
        end
        mem_req_prev = mem_req;
        if (if_rvalid) begin
            tests++;
            if (exp_if_q.size() == 0) begin
                fails++;
                $display("FAIL if_rvalid: unexpected pulse, rdata=%h", if_rdata);
            end else begin
                mon_d = exp_if_q.pop_front();
                if (if_rdata !== mon_d) begin
                    fails++;
                    $display("FAIL if_rdata: got %h want %h", if_rdata, mon_d);
                end
            end
        end
        if (d_rvalid) begin
            tests++;
            if (exp_d_q.size() == 0) begin
                fails++;
                $display("FAIL d_rvalid: unexpected pulse, rdata=%h", d_rdata);
            end else begin
                mon_d = exp_d_q.pop_front();
                if (d_rdata !== mon_d) begin
                    fails++;
                    $display("FAIL d_rdata: got %h want %h", d_rdata, mon_d);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(3);
        tests++;
        if ({mem_req, busy, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_we} !== 7'b0) begin
            fails++;
            $display("FAIL reset_ctrl: req/busy/ig/dg/irv/drv/we=%b want 0000000",
                     {mem_req, busy, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_we});
        end
        tests++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0 ||
            if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_data: addr=%h wdata=%h wstrb=%b if_rdata=%h d_rdata=%h want all 0",
                     mem_addr, mem_wdata, mem_wstrb, if_rdata, d_rdata);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_fetch_only;
        ack_delay = 1;
        push_fetch(32'h100, 1'b1);
        if_req = 1'b1; if_addr = 32'h100;
        tick(1);
        tests++;
        if (if_gnt !== 1'b1 || mem_req !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL fetch_gnt: gnt=%0b req=%0b busy=%0b want 1 1 1", if_gnt, mem_req, busy);
        end
        if_req = 1'b0;
        tick(1);
        tests++;
        if (if_gnt !== 1'b0 || if_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL fetch_pulse: gnt=%0b rvalid=%0b want 0 0", if_gnt, if_rvalid);
        end
        tick(1);
        tests++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h0000_0013) begin
            fails++;
            $display("FAIL fetch_rvalid: rvalid=%0b rdata=%h want 1 00000013", if_rvalid, if_rdata);
        end
        tests++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL fetch_done: req=%0b busy=%0b want 0 0", mem_req, busy);
        end
        tick(1);
    endtask

    task automatic test_data_priority;
        push_load(32'h2000, 1'b1);
        push_fetch(32'h200, 1'b1);
        if_req = 1'b1; if_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        tick(1);
        tests++;
        if (d_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_addr !== 32'h2000) begin
            fails++;
            $display("FAIL prio_gnt: d_gnt=%0b if_gnt=%0b addr=%h want 1 0 00002000", d_gnt, if_gnt, mem_addr);
        end
        d_req = 1'b0;
        tick(2);
        tests++;
        if (d_rvalid !== 1'b1 || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL prio_drv: d_rvalid=%0b req=%0b want 1 0", d_rvalid, mem_req);
        end
        tick(1);
        tests++;
        if (mem_req !== 1'b1 || if_gnt !== 1'b1 || mem_addr !== 32'h200) begin
            fails++;
            $display("FAIL prio_fetch: req=%0b if_gnt=%0b addr=%h want 1 1 00000200", mem_req, if_gnt, mem_addr);
        end
        if_req = 1'b0;
        tick(4);
    endtask

    task automatic test_starvation;
        bit got[10];
        bit want[10];
        int n = 0;
        want = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        for (int k = 0; k < 4; k++) push_load(32'h4000 + 32'(4 * k), 1'b1);
        push_fetch(32'h800, 1'b1);
        for (int k = 4; k < 8; k++) push_load(32'h4000 + 32'(4 * k), 1'b1);
        push_fetch(32'h804, 1'b1);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000;
        if_req = 1'b1; if_addr = 32'h800;
        for (int c = 0; c < 80 && n < 10; c++) begin
            tick(1);
            if (d_gnt && n < 10) begin
                got[n] = 1'b0; n++; d_addr = d_addr + 32'h4;
            end
            if (if_gnt && n < 10) begin
                got[n] = 1'b1; n++; if_addr = if_addr + 32'h4;
            end
        end
        d_req = 1'b0; if_req = 1'b0;
        tests++;
        if (n != 10) begin
            fails++;
            $display("FAIL starve_count: got %0d grants want 10", n);
        end
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (got[i] !== want[i]) begin
                fails++;
                $display("FAIL starve_seq[%0d]: got %s want %s", i, got[i] ? "fetch" : "data", want[i] ? "fetch" : "data");
            end
        end
        tick(4);
    endtask

    task automatic test_store_slow;
        ack_delay = 5;
        push_store(32'h3004, 32'hDEAD_BEEF, 4'b0011);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3004; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
        tick(1);
        tests++;
        if (d_gnt !== 1'b1) begin
            fails++;
            $display("FAIL store_gnt: d_gnt=%0b want 1", d_gnt);
        end
        d_req = 1'b0; d_we = 1'b0; d_wdata = 32'h0; d_wstrb = 4'h0;
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h3004 ||
                mem_wdata !== 32'hDEAD_BEEF || mem_wstrb !== 4'b0011 || d_rvalid !== 1'b0) begin
                fails++;
                $display("FAIL store_hold[%0d]: req=%0b we=%0b addr=%h wdata=%h wstrb=%b rvalid=%0b", k,
                         mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, d_rvalid);
            end
            tick(1);
        end
        tick(1);
        tests++;
        if (d_rvalid !== 1'b1 || d_rdata !== last_load) begin
            fails++;
            $display("FAIL store_done: rvalid=%0b rdata=%h want 1 %h", d_rvalid, d_rdata, last_load);
        end
        tick(1);
        ack_delay = 1;
    endtask

    task automatic test_flush;
        ack_delay = 2;
        push_fetch(32'h900, 1'b0);
        if_req = 1'b1; if_addr = 32'h900;
        tick(1);
        tests++;
        if (if_gnt !== 1'b1) begin
            fails++;
            $display("FAIL flush_gnt: if_gnt=%0b want 1", if_gnt);
        end
        if_req = 1'b0; if_flush = 1'b1;
        tick(1);
        if_flush = 1'b0;
        tick(2);
        tests++;
        if (if_rvalid !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL flush_drop: rvalid=%0b busy=%0b req=%0b want 0 0 0", if_rvalid, busy, mem_req);
        end
        push_fetch(32'h904, 1'b1);
        if_req = 1'b1; if_addr = 32'h904;
        tick(1);
        tests++;
        if (if_gnt !== 1'b1) begin
            fails++;
            $display("FAIL flush_next_gnt: if_gnt=%0b want 1", if_gnt);
        end
        if_req = 1'b0;
        tick(3);
        tests++;
        if (if_rvalid !== 1'b1 || if_rdata !== mem_val(32'h904)) begin
            fails++;
            $display("FAIL flush_next_data: rvalid=%0b rdata=%h want 1 %h", if_rvalid, if_rdata, mem_val(32'h904));
        end
        tick(1);
        if_req = 1'b1; if_addr = 32'hA00; if_flush = 1'b1;
        tick(1);
        tests++;
        if (if_gnt !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle: if_gnt=%0b busy=%0b want 0 0", if_gnt, busy);
        end
        if_req = 1'b0; if_flush = 1'b0;
        tick(1);
        ack_delay = 1;
    endtask

    task automatic test_reset_mid;
        resp_en = 1'b0;
        push_load(32'h5000, 1'b0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000;
        tick(1);
        tests++;
        if (d_gnt !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_gnt: d_gnt=%0b want 1", d_gnt);
        end
        d_req = 1'b0;
        tick(1);
        tests++;
        if (mem_req !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_pending: req=%0b busy=%0b want 1 1", mem_req, busy);
        end
        rst = 1'b1;
        tick(1);
        tests++;
        if ({mem_req, busy, d_gnt, d_rvalid, if_gnt, if_rvalid} !== 6'b0 || mem_addr !== 32'h0 || d_rdata !== 32'h0) begin
            fails++;
            $display("FAIL rstmid_clear: ctrl=%b addr=%h d_rdata=%h want 000000 0 0",
                     {mem_req, busy, d_gnt, d_rvalid, if_gnt, if_rvalid}, mem_addr, d_rdata);
        end
        rst = 1'b0;
        last_load = 32'h0;
        man_ack = 1'b1;
        tick(1);
        man_ack = 1'b0;
        tick(1);
        tests++;
        if (d_rvalid !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_stray_ack: rvalid=%0b busy=%0b req=%0b want 0 0 0", d_rvalid, busy, mem_req);
        end
        tick(2);
        resp_en = 1'b1;
        tick(1);
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;

        test_reset;
        test_fetch_only;
        test_data_priority;
        test_starvation;
        test_store_slow;
        test_flush;
        test_reset_mid;

        tests++;
        if (exp_mem_q.size() != 0 || exp_if_q.size() != 0 || exp_d_q.size() != 0) begin
            fails++;
            $display("FAIL drain: left mem=%0d if=%0d d=%0d want 0 0 0",
                     exp_mem_q.size(), exp_if_q.size(), exp_d_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
